// File: rtl/seg7_pkg.sv
// Shared segment encodings (active low, {a,b,c,d,e,f,g,dp}) and the hex decoder
// used by the multiplexed 7-segment controller.
package seg7_pkg;

    localparam logic [7:0] SEG_0   = 8'h03;
    localparam logic [7:0] SEG_1   = 8'h9F;
    localparam logic [7:0] SEG_2   = 8'h25;
    localparam logic [7:0] SEG_3   = 8'h0D;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h49;
    localparam logic [7:0] SEG_6   = 8'h41;
    localparam logic [7:0] SEG_7   = 8'h1F;
    localparam logic [7:0] SEG_8   = 8'h01;
    localparam logic [7:0] SEG_9   = 8'h09;
    localparam logic [7:0] SEG_A   = 8'h11;
    localparam logic [7:0] SEG_B   = 8'hC1;
    localparam logic [7:0] SEG_C   = 8'h63;
    localparam logic [7:0] SEG_D   = 8'h85;
    localparam logic [7:0] SEG_E   = 8'h61;
    localparam logic [7:0] SEG_F   = 8'h71;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Returned pattern has the dp bit dark; callers overwrite bit 0.
    function automatic logic [7:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0:    hex2seg = SEG_0;
            4'h1:    hex2seg = SEG_1;
            4'h2:    hex2seg = SEG_2;
            4'h3:    hex2seg = SEG_3;
            4'h4:    hex2seg = SEG_4;
            4'h5:    hex2seg = SEG_5;
            4'h6:    hex2seg = SEG_6;
            4'h7:    hex2seg = SEG_7;
            4'h8:    hex2seg = SEG_8;
            4'h9:    hex2seg = SEG_9;
            4'hA:    hex2seg = SEG_A;
            4'hB:    hex2seg = SEG_B;
            4'hC:    hex2seg = SEG_C;
            4'hD:    hex2seg = SEG_D;
            4'hE:    hex2seg = SEG_E;
            default: hex2seg = SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/seg7_rate_gen.sv
// Digit-slot divider: q counts 0..DIV-1 and tick is high during the last count.
module seg7_rate_gen #(
    parameter int DIV = 16000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int QW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [QW-1:0] QMAX = QW'(DIV - 1);

    logic [QW-1:0] q;

    assign tick = (q == QMAX);

    always_ff @(posedge clk) begin
        if (rst)       q <= '0;
        else if (tick) q <= '0;
        else           q <= q + QW'(1);
    end
endmodule

// File: rtl/seg7_scan_ctrl.sv
// N-digit multiplexed 7-segment scanner with frame-synchronous snapshot, leading-zero
// blanking and display enable. Optional SEG7_DIM_EN adds PWM dimming via bright[3:0].
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DIV    = 16000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   din,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  blank_lz,
    input  logic                  disp_en,
`ifdef SEG7_DIM_EN
    input  logic [3:0]            bright,
`endif
    output logic [DIGITS-1:0]     AN,
    output logic [7:0]            SEG,
    output logic                  frame_tick
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

    logic                   tick;
    logic                   wrap;
    logic [IW-1:0]          idx;
    logic [DIGITS-1:0][3:0] snap_nib;
    logic [DIGITS-1:0]      snap_dp;
    logic [DIGITS-1:0]      blanked;
    logic                   lz_run;
    logic [DIGITS-1:0]      an_nxt;
    logic [7:0]             seg_nxt;

    seg7_rate_gen #(.DIV(DIV)) u_rate (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign wrap = tick && (idx == IMAX);

    // Snapshot only at the frame boundary so a frame never mixes old and new data.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx        <= '0;
            snap_nib   <= '0;
            snap_dp    <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= wrap;
            if (tick) idx <= wrap ? '0 : idx + IW'(1);
            if (wrap) begin
                snap_nib <= din;
                snap_dp  <= dp;
            end
        end
    end

    // A digit is blanked when it and every digit above it are zero; digit 0 never is.
    always_comb begin
        lz_run  = blank_lz;
        blanked = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            lz_run     = lz_run && (snap_nib[i] == 4'h0);
            blanked[i] = lz_run;
        end
    end

`ifdef SEG7_DIM_EN
    logic [3:0] phase;

    always_ff @(posedge clk) begin
        if (rst) phase <= 4'h0;
        else     phase <= phase + 4'h1;
    end
`endif

    always_comb begin
        an_nxt  = '1;
        seg_nxt = SEG_OFF;
        if (disp_en) begin
            an_nxt[idx] = 1'b0;
            seg_nxt     = blanked[idx] ? SEG_OFF : hex2seg(snap_nib[idx]);
            seg_nxt[0]  = ~snap_dp[idx];
        end
`ifdef SEG7_DIM_EN
        if (phase > bright) an_nxt = '1;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            AN  <= '1;
            SEG <= SEG_OFF;
        end else begin
            AN  <= an_nxt;
            SEG <= seg_nxt;
        end
    end
endmodule
